// File: rtl/pe_window_scheduler_pkg.sv
// Shared constants for the PE 1-D convolution window scheduler:
// FSM state encoding and default parameter widths.
package pe_window_scheduler_pkg;

  localparam int CONFIG_BIT_DEF = 4;
  localparam int ADDR_W_DEF     = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pe_window_scheduler_if.sv
// Control/config/datapath-facing bundle of the window scheduler.
// i_* are driven by the PE control and datapath, o_* by the scheduler.
interface pe_window_scheduler_if
  import pe_window_scheduler_pkg::*;
#(
  parameter int CONFIG_BIT = CONFIG_BIT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) ();

  logic                  i_start;
  logic [CONFIG_BIT-1:0] i_filter_size;
  logic [CONFIG_BIT-1:0] i_stride;
  logic [ADDR_W-1:0]     i_ifmap_len;
  logic                  i_mac_ready;
  logic [ADDR_W-1:0]     o_ifmap_addr;
  logic [CONFIG_BIT-1:0] o_filt_addr;
  logic                  o_mac_en;
  logic                  o_mac_clr;
  logic                  o_psum_valid;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;

  modport master (
    output i_start, i_filter_size, i_stride, i_ifmap_len, i_mac_ready,
    input  o_ifmap_addr, o_filt_addr, o_mac_en, o_mac_clr, o_psum_valid,
           o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_filter_size, i_stride, i_ifmap_len, i_mac_ready,
    output o_ifmap_addr, o_filt_addr, o_mac_en, o_mac_clr, o_psum_valid,
           o_busy, o_done, o_err
  );

endinterface

// File: rtl/pe_tap_counter.sv
// Modulo-size tap counter: init clears, inc steps, wraps to 0 after size-1.
module pe_tap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_init,
  input  logic         i_inc,
  input  logic [W-1:0] i_size,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = (r_count == (i_size - W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_init) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/pe_window_scheduler.sv
// Walks filter taps over an ifmap row, one tap per ready cycle, advancing the
// window by stride and pulsing psum_valid after each window's last tap.
module pe_window_scheduler
  import pe_window_scheduler_pkg::*;
#(
  parameter int CONFIG_BIT = CONFIG_BIT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_window_scheduler_if.slave bus
);

  // One extra bit so win + stride + fs never wraps in the end-of-row test.
  localparam int CMP_W = ADDR_W + 1;

  logic [1:0]            r_state;
  logic [CONFIG_BIT-1:0] r_fs;
  logic [CONFIG_BIT-1:0] r_stride;
  logic [ADDR_W-1:0]     r_len;
  logic [ADDR_W-1:0]     r_win;
  logic                  r_psum_valid;
  logic                  r_err;

  logic [CONFIG_BIT-1:0] w_tap;
  logic                  w_wrap;
  logic                  w_mac_en;
  logic                  w_last;
  logic                  w_cfg_bad;
  logic                  w_accept;
  logic                  w_fin;
  logic [CMP_W-1:0]      w_next_win;
  logic [CMP_W-1:0]      w_win_end;

  assign w_cfg_bad = (bus.i_filter_size == '0) || (bus.i_stride == '0) ||
                     (CMP_W'(bus.i_filter_size) > CMP_W'(bus.i_ifmap_len));
  assign w_accept  = (r_state == ST_IDLE) && bus.i_start && !w_cfg_bad;
  assign w_mac_en  = (r_state == ST_RUN) && bus.i_mac_ready;
  assign w_last    = w_mac_en && w_wrap;

  assign w_next_win = CMP_W'(r_win) + CMP_W'(r_stride);
  assign w_win_end  = w_next_win + CMP_W'(r_fs);
  assign w_fin      = (w_win_end > CMP_W'(r_len));

  pe_tap_counter #(
    .W (CONFIG_BIT)
  ) u_tap_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_init  (w_accept),
    .i_inc   (w_mac_en),
    .i_size  (r_fs),
    .o_count (w_tap),
    .o_wrap  (w_wrap)
  );

  assign bus.o_ifmap_addr = r_win + ADDR_W'(w_tap);
  assign bus.o_filt_addr  = w_tap;
  assign bus.o_mac_en     = w_mac_en;
  assign bus.o_mac_clr    = w_mac_en && (w_tap == '0);
  assign bus.o_psum_valid = r_psum_valid;
  assign bus.o_busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign bus.o_done       = (r_state == ST_DONE);
  assign bus.o_err        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fs         <= '0;
      r_stride     <= '0;
      r_len        <= '0;
      r_win        <= '0;
      r_psum_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // The psum register in the datapath holds the full sum one cycle later.
      r_psum_valid <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_fs     <= bus.i_filter_size;
              r_stride <= bus.i_stride;
              r_len    <= bus.i_ifmap_len;
              r_win    <= '0;
              r_err    <= 1'b0;
              r_state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_win <= w_next_win[ADDR_W-1:0];
            if (w_fin) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_window_scheduler.sv
// Self-checking bench for pe_window_scheduler: directed vector table, corner
// sequences and randomized rows checked against a tap-list reference model.
module tb_pe_window_scheduler;
  import pe_window_scheduler_pkg::*;

  localparam int CB = 4;
  localparam int AW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_window_scheduler_if #(.CONFIG_BIT(CB), .ADDR_W(AW)) bus ();

  pe_window_scheduler #(.CONFIG_BIT(CB), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic start;
    int   en, clr, ia, fa, pv, dn, bz;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cfg(input int fs, input int st, input int len);
    bus.i_filter_size = CB'(fs);
    bus.i_stride      = CB'(st);
    bus.i_ifmap_len   = AW'(len);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " mac_en"}, int'(bus.o_mac_en), 0);
    chk({tag, " mac_clr"}, int'(bus.o_mac_clr), 0);
    chk({tag, " psum_valid"}, int'(bus.o_psum_valid), 0);
    chk({tag, " busy"}, int'(bus.o_busy), 0);
    chk({tag, " done"}, int'(bus.o_done), 0);
    chk({tag, " err"}, int'(bus.o_err), 0);
    chk({tag, " ifmap_addr"}, int'(bus.o_ifmap_addr), 0);
    chk({tag, " filt_addr"}, int'(bus.o_filt_addr), 0);
  endtask

  // Reference: the row is a flat list of (window start, tap) operations issued
  // in order, one per ready cycle; done follows the last one.
  task automatic run_check(input int fs, input int st, input int len, input int mode,
                           input bit poke, output int done_cyc, output int psums);
    int  qw[$];
    int  qt[$];
    int  k;
    bit  pend;
    bit  rdy;
    bit  finished;
    for (int w = 0; w + fs <= len; w += st)
      for (int t = 0; t < fs; t++) begin
        qw.push_back(w);
        qt.push_back(t);
      end
    k = 0; pend = 0; done_cyc = -1; psums = 0; finished = 0;
    for (int c = 0; !finished && c < 1000; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(c == 2 || c == 3);
        default: rdy = ($urandom % 4) != 0;
      endcase
      bus.i_mac_ready = rdy;
      if (c == 0) begin
        bus.i_start = 1'b1;
        drive_cfg(fs, st, len);
      end else begin
        bus.i_start = poke && (c == 2);
        if (poke && c == 2) drive_cfg(0, 0, 0);
        else drive_cfg(int'($urandom % 16), int'($urandom % 16), int'($urandom % 64));
      end
      @(negedge clk);
      if (bus.o_psum_valid) psums++;
      if (c == 0) begin
        chk("start busy", int'(bus.o_busy), 0);
        chk("start mac_en", int'(bus.o_mac_en), 0);
      end else if (k < qw.size()) begin
        chk("run busy", int'(bus.o_busy), 1);
        chk("run done", int'(bus.o_done), 0);
        chk("run err", int'(bus.o_err), 0);
        chk("run psum_valid", int'(bus.o_psum_valid), int'(pend));
        chk("run mac_en", int'(bus.o_mac_en), int'(rdy));
        chk("run ifmap_addr", int'(bus.o_ifmap_addr), qw[k] + qt[k]);
        chk("run filt_addr", int'(bus.o_filt_addr), qt[k]);
        chk("run mac_clr", int'(bus.o_mac_clr), int'(rdy && qt[k] == 0));
        pend = rdy && (qt[k] == fs - 1);
        if (rdy) k++;
      end else if (done_cyc < 0) begin
        chk("final done", int'(bus.o_done), 1);
        chk("final busy", int'(bus.o_busy), 1);
        chk("final psum_valid", int'(bus.o_psum_valid), int'(pend));
        chk("final mac_en", int'(bus.o_mac_en), 0);
        done_cyc = c;
        pend = 0;
      end else begin
        chk("post busy", int'(bus.o_busy), 0);
        chk("post done", int'(bus.o_done), 0);
        chk("post psum_valid", int'(bus.o_psum_valid), 0);
        finished = 1;
      end
    end
    bus.i_start = 1'b0;
    if (!finished) chk("run timeout", 0, 1);
  endtask

  task automatic bad_cfg(input int fs, input int st, input int len);
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    drive_cfg(fs, st, len);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("cfg err", int'(bus.o_err), 1);
      chk("cfg busy", int'(bus.o_busy), 0);
      chk("cfg done", int'(bus.o_done), 0);
      chk("cfg mac_en", int'(bus.o_mac_en), 0);
      @(posedge clk); #1;
    end
  endtask

  int dc;
  int np;

  initial begin
    tbl[0]  = '{1'b1, 0, 0,  0,  0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1, 1,  0,  0, 0, 0, 1};
    tbl[2]  = '{1'b0, 1, 0,  1,  1, 0, 0, 1};
    tbl[3]  = '{1'b0, 1, 0,  2,  2, 0, 0, 1};
    tbl[4]  = '{1'b0, 1, 1,  1,  0, 1, 0, 1};
    tbl[5]  = '{1'b0, 1, 0,  2,  1, 0, 0, 1};
    tbl[6]  = '{1'b0, 1, 0,  3,  2, 0, 0, 1};
    tbl[7]  = '{1'b0, 1, 1,  2,  0, 1, 0, 1};
    tbl[8]  = '{1'b0, 1, 0,  3,  1, 0, 0, 1};
    tbl[9]  = '{1'b0, 1, 0,  4,  2, 0, 0, 1};
    tbl[10] = '{1'b0, 0, 0, -1, -1, 1, 1, 1};
    tbl[11] = '{1'b0, 0, 0, -1, -1, 0, 0, 0};

    bus.i_start = 1'b0;
    bus.i_mac_ready = 1'b1;
    drive_cfg(3, 1, 5);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fs=3 stride=1 len=5, start in cycle 0
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus.i_start = tbl[i].start;
      bus.i_mac_ready = 1'b1;
      drive_cfg(3, 1, 5);
      @(negedge clk);
      chk($sformatf("tbl%0d mac_en", i), int'(bus.o_mac_en), tbl[i].en);
      chk($sformatf("tbl%0d mac_clr", i), int'(bus.o_mac_clr), tbl[i].clr);
      chk($sformatf("tbl%0d psum_valid", i), int'(bus.o_psum_valid), tbl[i].pv);
      chk($sformatf("tbl%0d done", i), int'(bus.o_done), tbl[i].dn);
      chk($sformatf("tbl%0d busy", i), int'(bus.o_busy), tbl[i].bz);
      if (tbl[i].ia >= 0) begin
        chk($sformatf("tbl%0d ifmap_addr", i), int'(bus.o_ifmap_addr), tbl[i].ia);
        chk($sformatf("tbl%0d filt_addr", i), int'(bus.o_filt_addr), tbl[i].fa);
      end
    end
    bus.i_start = 1'b0;

    run_check(3, 2, 7, 0, 0, dc, np);
    chk("stride2 psums", np, 3);
    chk("stride2 done cycle", dc, 10);

    run_check(3, 1, 5, 1, 0, dc, np);
    chk("stall done cycle", dc, 12);
    chk("stall psums", np, 3);

    bad_cfg(0, 1, 5);
    run_check(3, 1, 5, 0, 0, dc, np);
    chk("err cleared", int'(bus.o_err), 0);
    bad_cfg(6, 1, 5);
    bad_cfg(2, 0, 5);

    // Reset in the middle of a row
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_mac_ready = 1'b1;
    drive_cfg(3, 1, 5);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1;
    @(negedge clk);
    chk("in reset psum_valid", int'(bus.o_psum_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("after reset psum_valid", int'(bus.o_psum_valid), 0);
    chk("after reset busy", int'(bus.o_busy), 0);
    run_check(3, 1, 5, 0, 0, dc, np);
    chk("rerun done cycle", dc, 10);
    chk("rerun psums", np, 3);

    run_check(3, 1, 5, 0, 1, dc, np);
    chk("poke done cycle", dc, 10);

    run_check(1, 1, 4, 0, 0, dc, np);
    chk("fs1 psums", np, 4);
    chk("fs1 done cycle", dc, 5);

    for (int r = 0; r < 30; r++) begin
      int fs, st, len;
      fs  = 1 + int'($urandom % 6);
      len = fs + int'($urandom % (21 - fs));
      st  = 1 + int'($urandom % 4);
      run_check(fs, st, len, 2, r[0], dc, np);
      chk($sformatf("rand%0d psums fs=%0d st=%0d len=%0d", r, fs, st, len),
          np, (len - fs) / st + 1);
    end

    for (int r = 0; r < 4; r++) begin
      int len;
      len = int'($urandom % 14);
      bad_cfg(len + 1 + int'($urandom % (15 - len)), 1 + int'($urandom % 15), len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
